// File: rtl/jstk2_poll_sequencer.sv
// Periodic PmodJSTK2 frame sequencer: chip-select timing, 5-byte exchange, timeout and atomic sample publish.
// Defining JSTK2_SEQ_LED_EN builds the LED colour latch so pending colours ride on the next frame.
module jstk2_poll_sequencer #(
    parameter int SS_SETUP_CYC    = 1500,
    parameter int BYTE_GAP_CYC    = 1000,
    parameter int POLL_PERIOD_CYC = 1000000,
    parameter int TIMEOUT_CYC     = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] led_r,
    input  logic [7:0] led_g,
    input  logic [7:0] led_b,
    input  logic       led_wr,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic       spi_done,
    input  logic [7:0] spi_rx,
    output logic       ss_n,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [1:0] btn,
    output logic       sample_valid,
    output logic       busy,
    output logic       err_timeout,
    output logic [2:0] dbg_state
);

    localparam int CMAX_A = (TIMEOUT_CYC > SS_SETUP_CYC) ? TIMEOUT_CYC : SS_SETUP_CYC;
    localparam int CMAX   = (CMAX_A > BYTE_GAP_CYC) ? CMAX_A : BYTE_GAP_CYC;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int PW     = $clog2(POLL_PERIOD_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_poll;
    logic [2:0]    r_idx;
    logic [7:0]    r_rx0;
    logic [1:0]    r_rx1;
    logic [7:0]    r_rx2;
    logic [1:0]    r_rx3;
    logic          w_launch;
    logic [7:0]    w_tx_byte;

    assign w_launch = (r_state == S_IDLE) && enable && (r_poll >= PW'(POLL_PERIOD_CYC - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_SETUP;
            S_SETUP: if (r_cnt == CW'(SS_SETUP_CYC - 1)) w_next = S_XFER;
            S_XFER:  w_next = S_WAIT;
            S_WAIT: begin
                if (spi_done) w_next = (r_idx == 3'd4) ? S_DONE : S_GAP;
                else if (r_cnt == CW'(TIMEOUT_CYC - 1)) w_next = S_ABORT;
            end
            S_GAP:   if (r_cnt == CW'(BYTE_GAP_CYC - 1)) w_next = S_XFER;
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ss_n         = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ABORT);
        busy         = ~ss_n;
        spi_start    = (r_state == S_XFER);
        spi_tx       = (r_state == S_XFER) ? w_tx_byte : 8'h00;
        sample_valid = (r_state == S_DONE);
    end

    assign dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_poll      <= '0;
            r_idx       <= 3'd0;
            r_rx0       <= 8'h00;
            r_rx1       <= 2'd0;
            r_rx2       <= 8'h00;
            r_rx3       <= 2'd0;
            x_pos       <= 10'd0;
            y_pos       <= 10'd0;
            btn         <= 2'd0;
            err_timeout <= 1'b0;
        end else begin
            r_state <= w_next;

            // Poll counter saturates so an overdue period launches at the next IDLE cycle.
            if (w_launch) r_poll <= '0;
            else if (r_poll != PW'(POLL_PERIOD_CYC - 1)) r_poll <= r_poll + PW'(1);

            // WAIT starts at 1 so the abort lands TIMEOUT_CYC cycles after spi_start.
            if (r_state != w_next) r_cnt <= (w_next == S_WAIT) ? CW'(1) : '0;
            else if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);

            if (w_launch) r_idx <= 3'd0;
            else if (r_state == S_GAP && w_next == S_XFER) r_idx <= r_idx + 3'd1;

            if (r_state == S_WAIT && spi_done) begin
                case (r_idx)
                    3'd0: r_rx0 <= spi_rx;
                    3'd1: r_rx1 <= spi_rx[1:0];
                    3'd2: r_rx2 <= spi_rx;
                    3'd3: r_rx3 <= spi_rx[1:0];
                    default: begin
                        x_pos <= {r_rx1, r_rx0};
                        y_pos <= {r_rx3, r_rx2};
                        btn   <= spi_rx[1:0];
                    end
                endcase
            end

            if (r_state == S_WAIT && w_next == S_ABORT) err_timeout <= 1'b1;
        end
    end

`ifdef JSTK2_SEQ_LED_EN
    logic [7:0] r_led_r, r_led_g, r_led_b;
    logic [7:0] r_fr_r, r_fr_g, r_fr_b;
    logic       r_pend, r_new_wr, r_fr_led;

    // r_new_wr marks a write since launch so completing the frame keeps the newer colour pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_led_r  <= 8'h00;
            r_led_g  <= 8'h00;
            r_led_b  <= 8'h00;
            r_fr_r   <= 8'h00;
            r_fr_g   <= 8'h00;
            r_fr_b   <= 8'h00;
            r_pend   <= 1'b0;
            r_new_wr <= 1'b0;
            r_fr_led <= 1'b0;
        end else begin
            if (w_launch) begin
                r_fr_r   <= r_led_r;
                r_fr_g   <= r_led_g;
                r_fr_b   <= r_led_b;
                r_fr_led <= r_pend;
                r_new_wr <= 1'b0;
            end
            if (r_state == S_DONE) r_pend <= r_new_wr;
            if (led_wr) begin
                r_led_r  <= led_r;
                r_led_g  <= led_g;
                r_led_b  <= led_b;
                r_pend   <= 1'b1;
                r_new_wr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tx_byte = 8'h00;
        if (r_fr_led) begin
            case (r_idx)
                3'd0:    w_tx_byte = 8'h84;
                3'd1:    w_tx_byte = r_fr_r;
                3'd2:    w_tx_byte = r_fr_g;
                3'd3:    w_tx_byte = r_fr_b;
                default: w_tx_byte = 8'h00;
            endcase
        end
    end
`else
    logic w_unused_led;
    assign w_unused_led = ^{led_r, led_g, led_b, led_wr};
    assign w_tx_byte    = 8'h00;
`endif

endmodule

// File: tb/tb_jstk2_poll_sequencer.sv
// Bench for jstk2_poll_sequencer: frame-timeline model checked every cycle, byte-engine responder, directed scenarios.
module tb_jstk2_poll_sequencer;

    localparam int SETUP     = 4;
    localparam int GAP       = 3;
    localparam int PERIOD    = 100;
    localparam int TMO       = 16;
    localparam int ENG_LAT   = 8;
    localparam int SLOT      = 1 + ENG_LAT + GAP;
    localparam int FRAME_END = 1 + SETUP + 4 * SLOT + ENG_LAT + 1;
`ifdef JSTK2_SEQ_LED_EN
    localparam bit LED = 1'b1;
`else
    localparam bit LED = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] led_r = 8'h00, led_g = 8'h00, led_b = 8'h00;
    logic       led_wr = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx = 8'h00;
    logic       spi_start, ss_n, sample_valid, busy, err_timeout;
    logic [7:0] spi_tx;
    logic [9:0] x_pos, y_pos;
    logic [1:0] btn;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_bytes [0:4];
    int withhold = -1;

    jstk2_poll_sequencer #(
        .SS_SETUP_CYC(SETUP), .BYTE_GAP_CYC(GAP), .POLL_PERIOD_CYC(PERIOD), .TIMEOUT_CYC(TMO)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .led_wr(led_wr),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
        .ss_n(ss_n), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
        .sample_valid(sample_valid), .busy(busy), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: frame timeline counted from the first ss_n-low cycle ----------------
    int         m_p = 1, m_end = FRAME_END, m_abyte = 0;
    bit         m_valid = 0, m_active = 0, m_abort = 0, m_fled = 0, m_pend = 0, m_newwr = 0, m_err = 0;
    logic [7:0] m_r = 0, m_g = 0, m_b = 0, m_fr = 0, m_fg = 0, m_fb = 0;
    logic [7:0] m_rx [0:4];
    logic [9:0] m_x = 0, m_y = 0;
    logic [1:0] m_btn = 0;

    function automatic logic [7:0] frame_byte(input int k);
        if (!m_fled) return 8'h00;
        case (k)
            0: return 8'h84;
            1: return m_fr;
            2: return m_fg;
            3: return m_fb;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clock) begin
        bit         in_frame, exp_start;
        logic [7:0] exp_tx;
        int         k;
        if (m_valid) begin
            in_frame  = m_active && (m_p < m_end);
            exp_start = 1'b0;
            exp_tx    = 8'h00;
            if (in_frame && m_p >= 1 + SETUP && ((m_p - 1 - SETUP) % SLOT) == 0) begin
                k = (m_p - 1 - SETUP) / SLOT;
                if (k <= (m_abort ? m_abyte : 4)) begin
                    exp_start = 1'b1;
                    exp_tx    = frame_byte(k);
                end
            end
            check("ss_n", ss_n, !in_frame);
            check("busy", busy, in_frame);
            check("spi_start", spi_start, exp_start);
            check("spi_tx", spi_tx, exp_tx);
            check("sample_valid", sample_valid, m_active && m_p == m_end && !m_abort);
            check("x_pos", x_pos, m_x);
            check("y_pos", y_pos, m_y);
            check("btn", btn, m_btn);
            check("err_timeout", err_timeout, m_err);
        end
        if (reset) begin
            m_active = 0; m_p = 1; m_err = 0; m_x = 0; m_y = 0; m_btn = 0;
            m_pend = 0; m_newwr = 0; m_fled = 0; m_valid = 1;
        end else begin
            if ((!m_active || m_p > m_end) && enable && m_p >= PERIOD) begin
                m_active = 1; m_p = 1; m_newwr = 0;
                m_fled = m_pend; m_fr = m_r; m_fg = m_g; m_fb = m_b;
                m_abort = (withhold >= 0); m_abyte = withhold;
                m_end = m_abort ? 1 + SETUP + SLOT * withhold + TMO : FRAME_END;
                for (int i = 0; i < 5; i++) m_rx[i] = rx_bytes[i];
            end else begin
`ifdef JSTK2_SEQ_LED_EN
                if (m_active && m_p == m_end && !m_abort) m_pend = m_newwr || led_wr;
`endif
                if (m_p < 1000) m_p++;
                if (m_active && m_p == m_end) begin
                    if (m_abort) m_err = 1;
                    else begin
                        m_x   = {m_rx[1][1:0], m_rx[0]};
                        m_y   = {m_rx[3][1:0], m_rx[2]};
                        m_btn = m_rx[4][1:0];
                    end
                end
            end
`ifdef JSTK2_SEQ_LED_EN
            if (led_wr) begin
                m_r = led_r; m_g = led_g; m_b = led_b; m_pend = 1; m_newwr = 1;
            end
`endif
        end
    end

    // ---------------- byte engine responder and event log ----------------
    int          ecyc = 0, byte_cnt = 0, done_at = -1, cur_n = 0, sv_count = 0;
    logic [7:0]  rx_pend = 8'h00;
    logic        prev_ss = 1'b1;
    logic [39:0] cur_bytes = 40'h0;
    int          fall_q[$], rise_q[$], start_q[$], done_q[$], fn_q[$];
    logic [39:0] frames_q[$];

    always @(negedge clock) begin
        ecyc++;
        if (ecyc == done_at) begin
            spi_done = 1'b1; spi_rx = rx_pend; done_q.push_back(ecyc);
        end else begin
            spi_done = 1'b0; spi_rx = 8'h00;
        end
        if (reset === 1'b1) begin byte_cnt = 0; done_at = -1; end
        if (spi_start === 1'b1) begin
            start_q.push_back(ecyc);
            cur_bytes = {cur_bytes[31:0], spi_tx};
            cur_n++;
            if (byte_cnt != withhold && byte_cnt <= 4) begin
                done_at = ecyc + ENG_LAT; rx_pend = rx_bytes[byte_cnt];
            end
            byte_cnt++;
        end
        if (ss_n === 1'b1) byte_cnt = 0;
        if (prev_ss === 1'b1 && ss_n === 1'b0) begin
            fall_q.push_back(ecyc); cur_bytes = 40'h0; cur_n = 0;
        end
        if (prev_ss === 1'b0 && ss_n === 1'b1) begin
            rise_q.push_back(ecyc); frames_q.push_back(cur_bytes); fn_q.push_back(cur_n);
        end
        if (sample_valid === 1'b1) sv_count++;
        prev_ss = ss_n;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_for(input int which, input int bound, input string name);
        bit hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(posedge clock); #1;
            case (which)
                0:       hit = (sample_valid === 1'b1);
                1:       hit = (err_timeout === 1'b1);
                2:       hit = (ss_n === 1'b0);
                default: hit = (start_q.size() >= 13);
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: event not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic drive_led(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(posedge clock); #1;
        led_r = r; led_g = g; led_b = b; led_wr = 1'b1;
        @(posedge clock); #1;
        led_wr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ss_n"}, ss_n, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_spi_start"}, spi_start, 1'b0);
        check({tag, "_spi_tx"}, spi_tx, 8'h00);
        check({tag, "_x"}, x_pos, 10'd0);
        check({tag, "_y"}, y_pos, 10'd0);
        check({tag, "_btn"}, btn, 2'd0);
        check({tag, "_sv"}, sample_valid, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    initial begin
        rx_bytes = '{8'h34, 8'h02, 8'hFF, 8'h01, 8'h03};
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check_reset_values("rst");
        enable = 1'b1;

        wait_for(0, 300, "frame0_sv");
        check("f0_x", x_pos, 10'h234);
        check("f0_y", y_pos, 10'h1FF);
        check("f0_btn", btn, 2'd3);
        drive_led(8'h11, 8'h22, 8'h33);
        wait_for(0, 300, "frame1_sv");
        wait_for(3, 300, "frame2_byte2");
        drive_led(8'hA1, 8'hB2, 8'hC3);
        wait_for(0, 300, "frame2_sv");
        rx_bytes = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00};
        wait_for(0, 300, "frame3_sv");
        check("f3_x", x_pos, 10'h001);
        check("f3_y", y_pos, 10'h002);
        check("f3_btn", btn, 2'd0);

        drive_led(8'h5A, 8'h6B, 8'h7C);
        withhold = 1;
        wait_for(1, 300, "frame4_timeout");
        check("abort_ss_n", ss_n, 1'b1);
        check("abort_sv", sample_valid, 1'b0);
        check("abort_x_kept", x_pos, 10'h001);
        withhold = -1;
        wait_for(0, 300, "frame5_sv");

        wait_for(2, 300, "frame6_launch");
        repeat (10) @(posedge clock);
        #1 enable = 1'b0;
        wait_for(0, 300, "frame6_sv");
        repeat (200) @(posedge clock);
        #1 check("no_launch_when_disabled", fall_q.size(), 7);

        enable = 1'b1;
        wait_for(2, 10, "frame7_launch");
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_reset_values("midrst");
        enable = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        checks++;
        if (frames_q.size() < 6 || start_q.size() < 22 || rise_q.size() < 5 || fall_q.size() < 2 || done_q.size() < 1) begin
            errors++;
            $display("FAIL event_log: frames=%0d starts=%0d required at least 6 and 22", frames_q.size(), start_q.size());
        end else begin
            check("frame0_bytes", frames_q[0], 40'h0);
            check("frame0_count", fn_q[0], 5);
            check("frame1_bytes", frames_q[1], LED ? 40'h84_11_22_33_00 : 40'h0);
            check("frame2_bytes", frames_q[2], 40'h0);
            check("frame3_bytes", frames_q[3], LED ? 40'h84_A1_B2_C3_00 : 40'h0);
            check("frame4_bytes", frames_q[4], LED ? 40'h00_00_00_84_5A : 40'h0);
            check("frame4_count", fn_q[4], 2);
            check("frame5_bytes", frames_q[5], LED ? 40'h84_5A_6B_7C_00 : 40'h0);
            check("setup_spacing", start_q[0] - fall_q[0], 4);
            check("gap_spacing", start_q[1] - done_q[0], 4);
            check("launch_period", fall_q[1] - fall_q[0], 100);
            check("timeout_spacing", rise_q[4] - start_q[21], 16);
        end
        check("sample_valid_count", sv_count, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
